// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// segment bit positions and the hex font table (active-low, dp excluded).
package fnd_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n holds segments g..a for hex digit n, low = lit.
    localparam logic [15:0][6:0] FONT_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational hex nibble to active-low a-g segment decoder.
module fnd_font_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = FONT_TABLE[nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment scanner with tear-free shadow loading.
// Define FND_LZB_EN to blank leading zero digits.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    output logic [DIGITS-1:0]     o_digit,
    output logic [7:0]            o_font,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0]         presc;
    logic [IW-1:0]         scan;
    logic [4*DIGITS-1:0]   active_value;
    logic [4*DIGITS-1:0]   shadow_value;
    logic [DIGITS-1:0]     active_dp;
    logic [DIGITS-1:0]     shadow_dp;
    logic                  pending;
    logic                  tick;
    logic                  wrap;
    logic [3:0]            nibble;
    logic [6:0]            segments;
    logic                  blank;

    assign tick         = (presc == CW'(CLK_DIV - 1));
    assign wrap         = tick && (scan == IW'(DIGITS - 1));
    assign o_busy       = pending;
    assign o_frame_done = wrap;
    assign nibble       = active_value[{scan, 2'b00} +: 4];

    fnd_font_decoder u_font (
        .nibble   (nibble),
        .segments (segments)
    );

`ifdef FND_LZB_EN
    logic [DIGITS-1:0] blank_mask;
    logic              zero_run;

    // Digit i is blank when it and every digit above it are zero.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run && (active_value[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end

    assign blank = blank_mask[scan];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc <= '0;
            scan  <= '0;
        end else begin
            presc <= tick ? '0 : presc + CW'(1);
            if (tick) begin
                scan <= wrap ? '0 : scan + IW'(1);
            end
        end
    end

    // Shadow is only promoted at a frame boundary so a frame never tears.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            active_value <= '0;
            active_dp    <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            pending      <= 1'b0;
        end else if (i_load && wrap) begin
            active_value <= i_value;
            active_dp    <= i_dp;
            shadow_value <= i_value;
            shadow_dp    <= i_dp;
            pending      <= 1'b0;
        end else if (i_load) begin
            shadow_value <= i_value;
            shadow_dp    <= i_dp;
            pending      <= 1'b1;
        end else if (wrap && pending) begin
            active_value <= shadow_value;
            active_dp    <= shadow_dp;
            pending      <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_en) begin
            o_digit <= '1;
            o_font  <= 8'hFF;
        end else begin
            o_digit <= ~(DIGITS'(1) << scan);
            o_font  <= {~active_dp[scan], blank ? 7'h7F : segments};
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized self-checking bench for fnd_scan_controller (DIGITS=4, CLK_DIV=4).
// Reference model works from elapsed cycles since reset and frame-level load rules.
module tb_fnd_scan_controller;

    logic        clk;
    logic        i_reset;
    logic        i_en;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  o_digit;
    logic [7:0]  o_font;
    logic        o_busy;
    logic        o_frame_done;

    int errors = 0;
    int checks = 0;

    // Model state: k = clock edges since reset released.
    int          k = 0;
    logic [15:0] m_active = '0;
    logic [3:0]  m_active_dp = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_shadow_dp = '0;
    logic        m_pending = 1'b0;

    fnd_scan_controller #(
        .DIGITS  (4),
        .CLK_DIV (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_en         (i_en),
        .i_load       (i_load),
        .i_value      (i_value),
        .i_dp         (i_dp),
        .o_digit      (o_digit),
        .o_font       (o_font),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h",
                     tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] digit_font(input int pos);
        logic [7:0] f;
        int msd;
        f = hex_font(m_active[4*pos +: 4]);
`ifdef FND_LZB_EN
        msd = 0;
        for (int i = 0; i < 4; i++)
            if (m_active[4*i +: 4] != 4'h0) msd = i;
        if (pos > msd) f = 8'hFF;
`else
        msd = 0;
`endif
        if (m_active_dp[pos]) f[7] = 1'b0;
        return f;
    endfunction

    task automatic step(input logic rst, input logic en, input logic load,
                        input logic [15:0] val, input logic [3:0] dp);
        logic [3:0] e_dig;
        logic [7:0] e_font;
        logic [3:0] one;
        int pos;
        bit wrap;
        i_reset = rst;
        i_en    = en;
        i_load  = load;
        i_value = val;
        i_dp    = dp;
        one     = 4'b0001;
        if (rst) begin
            e_dig       = 4'hF;
            e_font      = 8'hFF;
            k           = 0;
            m_active    = '0;
            m_active_dp = '0;
            m_shadow    = '0;
            m_shadow_dp = '0;
            m_pending   = 1'b0;
        end else begin
            pos  = (k / 4) % 4;
            wrap = (k % 16) == 15;
            e_dig  = en ? ~(one << pos) : 4'hF;
            e_font = en ? digit_font(pos) : 8'hFF;
            if (load && wrap) begin
                m_active = val; m_active_dp = dp;
                m_shadow = val; m_shadow_dp = dp;
                m_pending = 1'b0;
            end else if (load) begin
                m_shadow = val; m_shadow_dp = dp;
                m_pending = 1'b1;
            end else if (wrap && m_pending) begin
                m_active = m_shadow; m_active_dp = m_shadow_dp;
                m_pending = 1'b0;
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("digit", 32'(o_digit), 32'(e_dig));
        check("font", 32'(o_font), 32'(e_font));
        check("busy", 32'(o_busy), 32'(m_pending));
        check("frame_done", 32'(o_frame_done), 32'((k % 16) == 15));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 16'h0, 4'h0);
    endtask

    task automatic idle_until(input int phase);
        while ((k % 16) != phase) step(0, 1, 0, 16'h0, 4'h0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_en    = 1'b0;
        i_load  = 1'b0;
        i_value = '0;
        i_dp    = '0;

        step(1, 0, 0, 16'h0, 4'h0);
        step(1, 1, 0, 16'h0, 4'h0);
        idle(40);

        idle_until(6);
        step(0, 1, 1, 16'h12AF, 4'b0100);
        idle(40);

        idle_until(3);
        step(0, 1, 1, 16'h1111, 4'h0);
        idle(4);
        step(0, 1, 1, 16'h2222, 4'h0);
        idle(24);

        idle_until(15);
        step(0, 1, 1, 16'h0050, 4'h0);
        idle(20);
        step(0, 1, 1, 16'h0000, 4'h0);
        idle(36);

        idle_until(5);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0, 4'h0);
        idle(20);

        idle_until(9);
        step(0, 1, 1, 16'hBEEF, 4'b1010);
        step(1, 1, 0, 16'h0, 4'h0);
        idle(36);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 300) == 0,
                 ($urandom % 12) != 0,
                 ($urandom % 6) == 0,
                 16'($urandom),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
